// File: rtl/fp32_add_arb_if.sv
// fp32_add_arb_if: requester, response and adder-stream signals of fp32_add_arb
//   slave  : arbiter side (drives req_ready, rsp_*, add_a/b_*, busy, err)
//   master : requester/adder side (drives pause, req_*, add_result_*)
interface fp32_add_arb_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic                 pause;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [31:0]          rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 add_a_tvalid;
  logic                 add_b_tvalid;
  logic [31:0]          add_a_tdata;
  logic [31:0]          add_b_tdata;
  logic                 add_result_tvalid;
  logic [31:0]          add_result_tdata;
  logic                 busy;
  logic                 err;
  modport slave (
    input  pause, req_valid, req_a, req_b, add_result_tvalid, add_result_tdata,
    output req_ready, rsp_valid, rsp_data, rsp_id, add_a_tvalid, add_b_tvalid,
           add_a_tdata, add_b_tdata, busy, err
  );
  modport master (
    output pause, req_valid, req_a, req_b, add_result_tvalid, add_result_tdata,
    input  req_ready, rsp_valid, rsp_data, rsp_id, add_a_tvalid, add_b_tvalid,
           add_a_tdata, add_b_tdata, busy, err
  );
endinterface

// File: rtl/fp32_add_arb.sv
// fp32_add_arb: round-robin share of one pipelined FP32 adder among NUM_REQ requesters
//   aclk, areset   : clock, asynchronous active-high reset
//   bus (slave)    : requester valid/ready/operands, one-hot response, adder streams, busy, err
//   stat_grant_cnt : per-requester 16-bit saturating grant counters (only with FP32_ADD_ARB_STATS_EN)
module fp32_add_arb #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 3
) (
  input  logic                  aclk,
  input  logic                  areset,
  fp32_add_arb_if.slave         bus
`ifdef FP32_ADD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] stat_grant_cnt
`endif
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [ID_W-1:0]      last_q;
  logic [ID_W-1:0]      gnt_id;
  logic [ID_W-1:0]      idx;
  logic                 found;
  logic                 hs;
  logic [31:0]          a_q;
  logic [31:0]          b_q;
  // Stage 0 sits beside the adder input register; stage ADD_LATENCY lines up with the adder result.
  logic [ADD_LATENCY:0] tag_v_q;
  logic [ID_W-1:0]      tag_id_q [ADD_LATENCY+1];
  logic                 err_q;
  logic                 err_d;
  logic                 tail_v;
  logic [ID_W-1:0]      tail_id;
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign hs            = found & ~bus.pause;
  assign bus.req_ready = hs ? NUM_REQ'(1) << gnt_id : '0;
  assign tail_v        = tag_v_q[ADD_LATENCY];
  assign tail_id       = tag_id_q[ADD_LATENCY];
  // Any disagreement between the adder result strobe and the tag tail is a lost or phantom result.
  assign err_d         = err_q | (bus.add_result_tvalid != tail_v);
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tag_v_q <= '0;
      for (int k = 0; k <= ADD_LATENCY; k++) tag_id_q[k] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      err_q   <= 1'b0;
    end else begin
      tag_v_q     <= {tag_v_q[ADD_LATENCY-1:0], hs};
      tag_id_q[0] <= gnt_id;
      for (int k = 1; k <= ADD_LATENCY; k++) tag_id_q[k] <= tag_id_q[k-1];
      if (hs) begin
        a_q    <= bus.req_a[gnt_id*32 +: 32];
        b_q    <= bus.req_b[gnt_id*32 +: 32];
        last_q <= gnt_id;
      end
      err_q <= err_d;
    end
  end
  assign bus.add_a_tvalid = tag_v_q[0];
  assign bus.add_b_tvalid = tag_v_q[0];
  assign bus.add_a_tdata  = a_q;
  assign bus.add_b_tdata  = b_q;
  // Results without a live tag are dropped (flagged by err) rather than steered to a stale id.
  assign bus.rsp_valid    = (bus.add_result_tvalid && tail_v) ? NUM_REQ'(1) << tail_id : '0;
  assign bus.rsp_data     = bus.add_result_tdata;
  assign bus.rsp_id       = tail_id;
  // The tail stage is returning this cycle, so it no longer counts as outstanding.
  assign bus.busy         = |tag_v_q[ADD_LATENCY-1:0];
  assign bus.err          = err_q;
`ifdef FP32_ADD_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
    end else if (hs && cnt_q[gnt_id] != 16'hFFFF) begin
      cnt_q[gnt_id] <= cnt_q[gnt_id] + 16'd1;
    end
  end
  for (genvar j = 0; j < NUM_REQ; j++) begin : g_stat
    assign stat_grant_cnt[16*j +: 16] = cnt_q[j];
  end
`endif
endmodule

// File: tb/tb_fp32_add_arb.sv
// tb_fp32_add_arb: directed table, hand sequences and randomized scoreboard checks of fp32_add_arb
module tb_fp32_add_arb;
  localparam int N = 4;
  localparam int LAT = 3;
  logic clk;
  logic rst;
  logic inj;
  logic [31:0] opa [N];
  logic [31:0] opb [N];
  logic [N-1:0] rv;
  int errors = 0;
  int checks = 0;
  int t = 0;
  int last = N - 1;
  typedef struct { int due; int id; logic [31:0] sum; } exp_t;
  exp_t q [$];
  typedef struct {
    logic [N-1:0] rv;
    logic [31:0]  b0;
    logic [N-1:0] ready;
    logic [N-1:0] rsp;
    logic [1:0]   id;
    logic [31:0]  data;
    logic         busy;
  } vec_t;
  fp32_add_arb_if #(.NUM_REQ(N)) bus ();
`ifdef FP32_ADD_ARB_STATS_EN
  logic [N*16-1:0] stat;
`endif
  fp32_add_arb #(.NUM_REQ(N), .ADD_LATENCY(LAT)) dut (
    .aclk(clk),
    .areset(rst),
    .bus(bus)
`ifdef FP32_ADD_ARB_STATS_EN
    ,
    .stat_grant_cnt(stat)
`endif
  );
  function automatic real f2d(logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction
  function automatic logic [31:0] d2f(real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (r == 0.0) return 32'd0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction
  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    return d2f(f2d(a) + f2d(b));
  endfunction
  logic [LAT-1:0] pv;
  logic [31:0] pd [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pd[i] <= '0;
    end else begin
      pv <= {pv[LAT-2:0], bus.add_a_tvalid};
      pd[0] <= fadd(bus.add_a_tdata, bus.add_b_tdata);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end
  assign bus.add_result_tvalid = pv[LAT-1] | inj;
  assign bus.add_result_tdata  = pd[LAT-1];
  assign bus.req_a = {opa[3], opa[2], opa[1], opa[0]};
  assign bus.req_b = {opb[3], opb[2], opb[1], opb[0]};
  assign bus.req_valid = rv;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s t=%0d got=%h want=%h", n, t, act, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    rv = '0;
    bus.pause = 1'b0;
    inj = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    q.delete();
    last = N - 1;
  endtask
  // One cycle against the scoreboard: round-robin grant from the current inputs,
  // results due this cycle, and outstanding work for busy.
  task automatic step(output int g);
    logic [N-1:0] eg;
    exp_t e;
    #1;
    eg = '0;
    g = -1;
    if (!bus.pause)
      for (int k = 1; k <= N; k++)
        if (g < 0 && rv[(last + k) % N]) g = (last + k) % N;
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(eg));
    if (q.size() > 0 && q[0].due == t) begin
      e = q.pop_front();
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.id);
      chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
      chk("rsp_data", bus.rsp_data, e.sum);
    end else begin
      chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
    end
    chk("busy", 32'(bus.busy), 32'(q.size() > 0));
    if (g >= 0) begin
      last = g;
      q.push_back('{t + 1 + LAT, g, fadd(opa[g], opb[g])});
    end
    tick();
  endtask
  initial begin
    vec_t tbl [14];
    int g;
    int np;
`ifdef FP32_ADD_ARB_STATS_EN
    logic [N*16-1:0] snap;
`endif
    tbl[0]  = '{4'b1111, 32'h0,        4'b0001, 4'b0000, 2'd0, 32'h0,        1'b0};
    tbl[1]  = '{4'b1110, 32'h0,        4'b0010, 4'b0000, 2'd0, 32'h0,        1'b1};
    tbl[2]  = '{4'b1100, 32'h0,        4'b0100, 4'b0000, 2'd0, 32'h0,        1'b1};
    tbl[3]  = '{4'b1000, 32'h0,        4'b1000, 4'b0000, 2'd0, 32'h0,        1'b1};
    tbl[4]  = '{4'b0000, 32'h0,        4'b0000, 4'b0001, 2'd0, 32'h3F800000, 1'b1};
    tbl[5]  = '{4'b0000, 32'h0,        4'b0000, 4'b0010, 2'd1, 32'h40000000, 1'b1};
    tbl[6]  = '{4'b0000, 32'h0,        4'b0000, 4'b0100, 2'd2, 32'h40400000, 1'b1};
    tbl[7]  = '{4'b0000, 32'h0,        4'b0000, 4'b1000, 2'd3, 32'h40800000, 1'b0};
    tbl[8]  = '{4'b0000, 32'h0,        4'b0000, 4'b0000, 2'd0, 32'h0,        1'b0};
    tbl[9]  = '{4'b0001, 32'h40000000, 4'b0001, 4'b0000, 2'd0, 32'h0,        1'b0};
    tbl[10] = '{4'b0000, 32'h40000000, 4'b0000, 4'b0000, 2'd0, 32'h0,        1'b1};
    tbl[11] = '{4'b0000, 32'h40000000, 4'b0000, 4'b0000, 2'd0, 32'h0,        1'b1};
    tbl[12] = '{4'b0000, 32'h40000000, 4'b0000, 4'b0000, 2'd0, 32'h0,        1'b1};
    tbl[13] = '{4'b0000, 32'h40000000, 4'b0000, 4'b0001, 2'd0, 32'h40400000, 1'b0};
    for (int i = 0; i < N; i++) begin
      opa[i] = 32'h3F800000;
      opb[i] = d2f(real'(i));
    end
    rst = 1'b1;
    rv = '0;
    bus.pause = 1'b0;
    inj = 1'b0;
    do_reset();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_tvalid", 32'(bus.add_a_tvalid), 32'd0);
    chk("rst_tdata", bus.add_a_tdata, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    for (int r = 0; r < 14; r++) begin
      rv = tbl[r].rv;
      opb[0] = tbl[r].b0;
      #1;
      chk($sformatf("tbl%0d_ready", r), 32'(bus.req_ready), 32'(tbl[r].ready));
      chk($sformatf("tbl%0d_rsp", r), 32'(bus.rsp_valid), 32'(tbl[r].rsp));
      chk($sformatf("tbl%0d_busy", r), 32'(bus.busy), 32'(tbl[r].busy));
      if (tbl[r].rsp != '0) begin
        chk($sformatf("tbl%0d_id", r), 32'(bus.rsp_id), 32'(tbl[r].id));
        chk($sformatf("tbl%0d_data", r), bus.rsp_data, tbl[r].data);
      end
      tick();
    end
    // back-to-back: requester 2 alone for 8 cycles
    do_reset();
    opa[2] = 32'h40A00000;
    np = 0;
    for (int c = 0; c < 16; c++) begin
      rv = (c < 8) ? 4'b0100 : 4'b0000;
      #1;
      if (bus.rsp_valid == 4'b0100) np++;
      step(g);
    end
    chk("b2b_pulses", np, 32'd8);
    // pause while requester 1 streams
    do_reset();
    for (int c = 0; c < 14; c++) begin
      rv = (c < 8) ? 4'b0010 : 4'b0000;
      bus.pause = (c >= 2 && c <= 5);
      step(g);
    end
    // reset with two operations in flight
    do_reset();
    rv = 4'b0001;
    step(g);
    step(g);
    rv = '0;
    rst = 1'b1;
    #1;
    chk("inrst_busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b0;
    q.delete();
    last = N - 1;
    for (int c = 0; c < 6; c++) step(g);
    chk("postrst_err", 32'(bus.err), 32'd0);
    rv = 4'b0011;
    #1;
    chk("postrst_first_grant", 32'(bus.req_ready), 32'b0001);
    step(g);
    rv = '0;
    for (int c = 0; c < 6; c++) step(g);
    // phantom result with an empty tag pipeline
    do_reset();
    inj = 1'b1;
    #1;
    chk("inj_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("inj_err_before", 32'(bus.err), 32'd0);
    tick();
    inj = 1'b0;
    chk("inj_err_set", 32'(bus.err), 32'd1);
    repeat (5) tick();
    chk("inj_err_sticky", 32'(bus.err), 32'd1);
    do_reset();
    chk("inj_err_cleared", 32'(bus.err), 32'd0);
    // randomized traffic against the scoreboard
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!rv[i] && $urandom_range(0, 1) == 1) begin
          rv[i] = 1'b1;
          opa[i] = d2f(real'($urandom_range(0, 200)));
          opb[i] = d2f(real'($urandom_range(0, 200)));
        end
      bus.pause = ($urandom_range(0, 7) == 0);
      step(g);
      if (g >= 0) rv[g] = 1'b0;
    end
    rv = '0;
    bus.pause = 1'b0;
    for (int c = 0; c < 8; c++) step(g);
    chk("rand_err", 32'(bus.err), 32'd0);
`ifdef FP32_ADD_ARB_STATS_EN
    snap = stat;
    rv = 4'b1000;
    repeat (70000) tick();
    rv = '0;
    chk("stat3_sat", 32'(stat[63:48]), 32'h0000FFFF);
    chk("stat0", 32'(stat[15:0]), 32'(snap[15:0]));
    chk("stat1", 32'(stat[31:16]), 32'(snap[31:16]));
    chk("stat2", 32'(stat[47:32]), 32'(snap[47:32]));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
